rf_parallel_rx: RTL
===================

RF_PARALLEL_RX -- requirements
Module: rf_parallel_rx

Receiver (RF-board end) of the parallel frequency-word interface. Captures a 16-bit word qualified by an active-high control window, checks it, then sequences a synthesiser lock period.

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 SHALL have parameters (name, default, meaning), one per line:
  SETTLE_CYC, 8, cycles ignored after window start
  STABLE_CNT, 4, consecutive equal samples required to accept a word
  WIN_MIN, 150, minimum legal window length in cycles
  WIN_MAX, 250, maximum legal window length in cycles
  LOCK_CYC, 64, synthesiser settle time in cycles
  FREQ_MAX, 16'd4000, largest legal frequency code
REQ-003 SHALL have ports (name, direction, width, meaning), one per line:
  clk  in  1  system clock
  rst_n  in  1  asynchronous active-low reset
  i_rf_freq  in  16  parallel frequency word, quasi-static
  i_rf_freq_ctrl  in  1  active-high capture window, asynchronous to clk
  o_freq  out  16  last accepted frequency word
  o_freq_vld  out  1  one-cycle pulse when o_freq updates
  o_lock  out  1  high when synthesiser is settled on o_freq
  o_err_short  out  1  one-cycle pulse: window too short or no stable word
  o_err_long  out  1  one-cycle pulse: window exceeded WIN_MAX
  o_err_range  out  1  one-cycle pulse: stable word > FREQ_MAX
  o_freq_cnt  out  8  count of accepted words, wraps 255->0

Function
REQ-004 SHALL pass i_rf_freq_ctrl through a 2-flop synchroniser plus one delay flop; rise/fall SHALL be detected on the synchronised signal.
REQ-005 SHALL register i_rf_freq each cycle (data_r); all comparisons use data_r.
REQ-006 SHALL implement FSM states IDLE, SETTLE, SAMPLE, WAIT_END, ABORT, LOCK.
REQ-007 SHALL keep a window counter: set to 1 on rise, increment each cycle while synced ctrl is high, saturate at WIN_MAX.
REQ-008 IDLE: on rise -> SETTLE.
REQ-009 SETTLE: after SETTLE_CYC cycles -> SAMPLE, clear the stable counter.
REQ-010 SAMPLE: if data_r equals the previous data_r, increment the stable counter, else clear it; on reaching STABLE_CNT-1, latch data_r as the candidate word -> WAIT_END.
REQ-011 A fall in SETTLE or SAMPLE SHALL pulse o_err_short -> IDLE, with no output update.
REQ-012 WAIT_END fall handling: window count < WIN_MIN -> o_err_short, IDLE; candidate > FREQ_MAX -> o_err_range, IDLE; otherwise load o_freq, pulse o_freq_vld, increment o_freq_cnt, clear o_lock -> LOCK.
REQ-013 o_freq_vld SHALL assert in the cycle after the synchronised fall is detected.
REQ-014 In SETTLE, SAMPLE or WAIT_END, the window count reaching WIN_MAX with ctrl still high SHALL pulse o_err_long -> ABORT; ABORT waits for fall -> IDLE, with no error on that fall.
REQ-015 LOCK: o_lock low for exactly LOCK_CYC cycles, then set o_lock high -> IDLE.
REQ-016 A rise during LOCK SHALL abandon the lock count, keep o_lock low, and go to SETTLE.
REQ-017 On any error, o_freq SHALL keep its previous value and o_lock SHALL be unchanged.
REQ-018 Rise and fall SHALL never be detected in the same cycle; error pulses SHALL be mutually exclusive per window.

Reset
REQ-019 On rst_n low: FSM = IDLE; all counters, synchroniser flops, data_r, candidate, o_freq and o_freq_cnt = 0; o_lock = 0; all pulse outputs = 0.
REQ-020 Reset mid-window SHALL discard the window; a window already high at reset release SHALL be ignored until it falls and rises again.

Structure
REQ-021 FSM state encoding and default parameter constants SHALL live in shared package rf_ctrl_pkg.
REQ-022 The synchroniser and edge detector SHALL be the sub-module rf_sync_edge (ports: clk, rst_n, i_async, o_level, o_rise, o_fall); everything else is in the top.

Verification
REQ-023 Word 16'h0123 stable; ctrl high 200 cycles -> one o_freq_vld, o_freq=16'h0123, o_freq_cnt=1, o_lock high 64 cycles after vld.
REQ-024 Ctrl high 100 cycles -> o_err_short; o_freq unchanged; no vld.
REQ-025 Ctrl held high 300 cycles -> o_err_long at window count 250; no vld; no error on the later fall.
REQ-026 Word 16'h1000 stable for 200 cycles -> o_err_range; o_freq and o_lock unchanged.
REQ-027 Word toggling every 2 cycles for the whole 200-cycle window -> o_err_short on fall.
REQ-028 Second window rising 20 cycles after the first vld -> o_lock stays low; second word accepted; o_lock high 64 cycles after the second vld.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared FSM encoding and default timing/limit constants for the RF parallel
// frequency-word receiver.
package rf_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_SAMPLE   = 3'd2;
  localparam logic [2:0] ST_WAIT_END = 3'd3;
  localparam logic [2:0] ST_ABORT    = 3'd4;
  localparam logic [2:0] ST_LOCK     = 3'd5;

  localparam int          DEF_SETTLE_CYC = 8;
  localparam int          DEF_STABLE_CNT = 4;
  localparam int          DEF_WIN_MIN    = 150;
  localparam int          DEF_WIN_MAX    = 250;
  localparam int          DEF_LOCK_CYC   = 64;
  localparam logic [15:0] DEF_FREQ_MAX   = 16'd4000;

endpackage

// File: rtl/rf_sync_edge.sv
// Two-flop synchroniser plus delay flop with rise/fall detection. A level that
// is already high when reset releases is masked until it has been seen low.
module rf_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic       sync1, sync2, dly, armed;
  logic [1:0] primed;

  // NOTE: every flop here uses <= so all stages sample the pre-edge values;
  // blocking assignments would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      dly    <= 1'b0;
      primed <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sync1  <= i_async;
      sync2  <= sync1;
      dly    <= sync2;
      primed <= {primed[0], 1'b1};
      // sync2 holds a real sample only once the pipeline has refilled.
      if (primed[1] && !sync2) armed <= 1'b1;
    end
  end

  assign o_level = sync2 & armed;
  assign o_rise  = sync2 & ~dly & armed;
  assign o_fall  = ~sync2 & dly & armed;

endmodule

// File: rtl/rf_parallel_rx.sv
// RF-board receiver: captures a stable 16-bit frequency word inside the
// control window, validates window length and range, then times synth lock.
module rf_parallel_rx
  import rf_ctrl_pkg::*;
#(
  parameter int          SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int          STABLE_CNT = DEF_STABLE_CNT,
  parameter int          WIN_MIN    = DEF_WIN_MIN,
  parameter int          WIN_MAX    = DEF_WIN_MAX,
  parameter int          LOCK_CYC   = DEF_LOCK_CYC,
  parameter logic [15:0] FREQ_MAX   = DEF_FREQ_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_rf_freq,
  input  logic        i_rf_freq_ctrl,
  output logic [15:0] o_freq,
  output logic        o_freq_vld,
  output logic        o_lock,
  output logic        o_err_short,
  output logic        o_err_long,
  output logic        o_err_range,
  output logic [7:0]  o_freq_cnt
);

  localparam int WW = $clog2(WIN_MAX + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(STABLE_CNT + 1);
  localparam int LW = $clog2(LOCK_CYC + 1);

  localparam logic [WW-1:0] WIN_MAX_C   = WW'(WIN_MAX);
  localparam logic [WW-1:0] WIN_MIN_C   = WW'(WIN_MIN);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CNT - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_CYC - 1);

  logic          ctrl_lvl, ctrl_rise, ctrl_fall;
  logic [15:0]   data_r, data_q, cand;
  logic [WW-1:0] win_cnt;
  logic [2:0]    state;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] stable_cnt, stable_nxt;
  logic [LW-1:0] lock_cnt;
  logic          win_long;

  rf_sync_edge u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_rf_freq_ctrl),
    .o_level (ctrl_lvl),
    .o_rise  (ctrl_rise),
    .o_fall  (ctrl_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= '0;
      data_q  <= '0;
      win_cnt <= '0;
    end else begin
      data_r <= i_rf_freq;
      data_q <= data_r;
      if (ctrl_rise)                           win_cnt <= WW'(1);
      else if (ctrl_lvl && win_cnt != WIN_MAX_C) win_cnt <= win_cnt + 1'b1;
    end
  end

  assign win_long = ctrl_lvl && (win_cnt == WIN_MAX_C);

  // NOTE: the default assignment first keeps this block purely combinational;
  // leaving any path unassigned would infer a latch.
  always_comb begin
    stable_nxt = '0;
    if (data_r == data_q) stable_nxt = stable_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      stable_cnt  <= '0;
      lock_cnt    <= '0;
      cand        <= '0;
      o_freq      <= '0;
      o_freq_cnt  <= '0;
      o_lock      <= 1'b0;
      o_freq_vld  <= 1'b0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
      o_err_range <= 1'b0;
    end else begin
      o_freq_vld  <= 1'b0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
      o_err_range <= 1'b0;
      case (state)
        ST_IDLE: if (ctrl_rise) begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (ctrl_fall) begin
            o_err_short <= 1'b1;
            state       <= ST_IDLE;
          end else if (win_long) begin
            o_err_long <= 1'b1;
            state      <= ST_ABORT;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= ST_SAMPLE;
            stable_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (ctrl_fall) begin
            o_err_short <= 1'b1;
            state       <= ST_IDLE;
          end else if (win_long) begin
            o_err_long <= 1'b1;
            state      <= ST_ABORT;
          end else begin
            stable_cnt <= stable_nxt;
            if (stable_nxt == STABLE_LAST) begin
              cand  <= data_r;
              state <= ST_WAIT_END;
            end
          end
        end
        ST_WAIT_END: begin
          if (ctrl_fall) begin
            state <= ST_IDLE;
            if (win_cnt < WIN_MIN_C) begin
              o_err_short <= 1'b1;
            end else if (cand > FREQ_MAX) begin
              o_err_range <= 1'b1;
            end else begin
              o_freq     <= cand;
              o_freq_vld <= 1'b1;
              o_freq_cnt <= o_freq_cnt + 1'b1;
              o_lock     <= 1'b0;
              lock_cnt   <= '0;
              state      <= ST_LOCK;
            end
          end else if (win_long) begin
            o_err_long <= 1'b1;
            state      <= ST_ABORT;
          end
        end
        ST_ABORT: if (ctrl_fall) state <= ST_IDLE;
        ST_LOCK: begin
          // A new window abandons the settle count; o_lock stays low.
          if (ctrl_rise) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end else if (lock_cnt == LOCK_LAST) begin
            o_lock <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
